// File: rtl/mem_stage.sv
// Memory stage: one load/store/pass-through bundle at a time, with a bounded wait on the data bus.
// Defining MEM_MISALIGN_CHECK_EN traps misaligned halfword/word accesses instead of issuing them.

package mem_stage_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_wr_en;
    logic [31:0] rd_res;
    mem_op_t     mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        mem_w_en;
  } pipeline_bus_t;

  localparam int BUS_BITS = $bits(pipeline_bus_t);

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd;
  } bypass_bus_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  pipeline_bus_t ex_bus_i,
  input  logic          ex_valid_i,
  output logic          mem_ready_o,
  output logic          dmem_req_o,
  output logic [3:0]    dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i,
  output pipeline_bus_t wb_bus_o,
  output logic          wb_valid_o,
  output bypass_bus_t   bypass_o,
  output logic          misalign_o,
  output logic          timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  // Extra headroom: a load granted on the last allowed cycle enters WAIT_R already past the limit.
  localparam int CNT_W = $clog2(MAX_WAIT + 2);

  state_t           state, state_next;
  pipeline_bus_t    bus;
  logic [CNT_W-1:0] wait_cnt;
  logic             ex_mem, ex_misalign, timed_out;

  function automatic logic is_load(mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic [3:0] store_be(mem_op_t op, logic [1:0] a);
    case (op)
      MEM_SB:  return 4'b0001 << a;
      MEM_SH:  return 4'b0011 << {a[1], 1'b0};
      MEM_SW:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(mem_op_t op, logic [31:0] w);
    case (op)
      MEM_SB:  return {4{w[7:0]}};
      MEM_SH:  return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(mem_op_t op, logic [1:0] a, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      MEM_LB:  return {{24{b[7]}}, b};
      MEM_LBU: return {24'd0, b};
      MEM_LH:  return {{16{h[15]}}, h};
      MEM_LHU: return {16'd0, h};
      default: return d;
    endcase
  endfunction

  assign ex_mem    = is_load(ex_bus_i.mem_op) || is_store(ex_bus_i.mem_op);
  assign timed_out = (wait_cnt >= CNT_W'(MAX_WAIT - 1));
  assign mem_ready_o = (state == IDLE);

`ifdef MEM_MISALIGN_CHECK_EN
  assign ex_misalign =
      ((ex_bus_i.mem_op inside {MEM_LH, MEM_LHU, MEM_SH}) && ex_bus_i.mem_addr[0]) ||
      ((ex_bus_i.mem_op inside {MEM_LW, MEM_SW}) && (ex_bus_i.mem_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_o <= 1'b0;
    else        misalign_o <= (state == IDLE) && ex_valid_i && ex_misalign;
  end
`else
  assign ex_misalign = 1'b0;
  assign misalign_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 4'b0000;
    dmem_addr_o  = 32'd0;
    dmem_wdata_o = 32'd0;
    case (state)
      IDLE: begin
        if (ex_valid_i && ex_mem && !ex_misalign) state_next = REQ;
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = store_be(bus.mem_op, bus.mem_addr[1:0]);
        dmem_addr_o  = {bus.mem_addr[31:2], 2'b00};
        dmem_wdata_o = store_data(bus.mem_op, bus.mem_w_data);
        if (dmem_gnt_i)     state_next = is_load(bus.mem_op) ? WAIT_R : IDLE;
        else if (timed_out) state_next = IDLE;
      end
      WAIT_R: begin
        if (dmem_rvalid_i || timed_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion (or abort) is always the cycle the FSM leaves REQ/WAIT_R, so wb follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus        <= '0;
      wait_cnt   <= '0;
      wb_bus_o   <= '0;
      wb_valid_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid_i) begin
            bus      <= ex_bus_i;
            wait_cnt <= '0;
            if (ex_misalign) begin
              wb_bus_o          <= ex_bus_i;
              wb_bus_o.rf_wr_en <= 1'b0;
              wb_bus_o.mem_w_en <= 1'b0;
              wb_valid_o        <= 1'b1;
            end else if (!ex_mem) begin
              wb_bus_o   <= ex_bus_i;
              wb_valid_o <= 1'b1;
            end
          end
        end
        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (dmem_gnt_i) begin
            if (!is_load(bus.mem_op)) begin
              wb_bus_o   <= bus;
              wb_valid_o <= 1'b1;
            end
          end else if (timed_out) begin
            wb_bus_o          <= bus;
            wb_bus_o.rf_wr_en <= 1'b0;
            wb_valid_o        <= 1'b1;
            timeout_o         <= 1'b1;
          end
        end
        WAIT_R: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (dmem_rvalid_i) begin
            wb_bus_o        <= bus;
            wb_bus_o.rd_res <= load_ext(bus.mem_op, bus.mem_addr[1:0], dmem_rdata_i);
            wb_valid_o      <= 1'b1;
          end else if (timed_out) begin
            wb_bus_o          <= bus;
            wb_bus_o.rf_wr_en <= 1'b0;
            wb_valid_o        <= 1'b1;
            timeout_o         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bypass_o.rd_addr = (wb_valid_o && wb_bus_o.rf_wr_en && (wb_bus_o.rd != 5'd0)) ? wb_bus_o.rd : 5'd0;
  assign bypass_o.rd      = wb_bus_o.rd_res;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized bundles and bus timing checked every cycle against a
// transaction-level model, plus directed corner cases and literal pins.

module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  pipeline_bus_t ex_bus;
  logic          ex_valid;
  logic          mem_ready;
  logic          dmem_req;
  logic [3:0]    dmem_we;
  logic [31:0]   dmem_addr, dmem_wdata, rdata;
  logic          gnt, rvalid;
  pipeline_bus_t wb_bus;
  logic          wb_valid;
  bypass_bus_t   bypass;
  logic          misalign, timeout;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_bus_i(ex_bus), .ex_valid_i(ex_valid), .mem_ready_o(mem_ready),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .wb_bus_o(wb_bus), .wb_valid_o(wb_valid), .bypass_o(bypass),
    .misalign_o(misalign), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    pipeline_bus_t bus;
    bit            to;
    bit            mis;
  } exp_t;

  int   chk_total = 0, chk_pass = 0, cyc = 0;
  bit   chk_en = 1'b0;
  exp_t exp_q[$];
  int   req_lo = 1, req_hi = 0, busy_lo = 1, busy_hi = 0;
  bit   exp_store;
  logic [3:0]  exp_we;
  logic [31:0] exp_addr, exp_wdata;

  logic [31:0] last_wb_res, last_req_wdata, last_req_addr;
  logic [3:0]  last_req_we;
  logic        last_wb_rfwe;
  bypass_bus_t last_bypass;
  int          last_to_cyc = -1, last_mis_cyc = -1;

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic bit model_misaligned(mem_op_t op, logic [31:0] a);
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (a % 2) != 0;
    if (op == MEM_LW || op == MEM_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_we(mem_op_t op, logic [31:0] a);
    case (op)
      MEM_SB:  return 4'(1 << (a % 4));
      MEM_SH:  return 4'(3 << (2 * ((a / 2) % 2)));
      MEM_SW:  return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(mem_op_t op, logic [31:0] d);
    case (op)
      MEM_SB:  return (d % 256) * 32'h0101_0101;
      MEM_SH:  return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(mem_op_t op, logic [31:0] a, logic [31:0] d);
    logic [31:0] v;
    case (op)
      MEM_LB, MEM_LBU: begin
        v = (d >> (8 * (a % 4))) % 256;
        if (op == MEM_LB && v >= 128) v = v - 256;
      end
      MEM_LH, MEM_LHU: begin
        v = (d >> (16 * ((a / 2) % 2))) % 65536;
        if (op == MEM_LH && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic pipeline_bus_t rand_bus();
    pipeline_bus_t b;
    b.pc         = $urandom;
    b.rd         = 5'($urandom);
    b.rf_wr_en   = 1'($urandom);
    b.rd_res     = $urandom;
    b.mem_op     = mem_op_t'($urandom_range(0, 8));
    b.mem_addr   = $urandom;
    b.mem_w_data = $urandom;
    b.mem_w_en   = 1'($urandom);
    return b;
  endfunction

  // One compare process: every sampled cycle is checked against the model's expectations.
  always @(posedge clk) begin : compare
    exp_t        e;
    bypass_bus_t eb;
    bit          due, in_req, in_busy;
    #1;
    cyc = cyc + 1;
    if (chk_en) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check_output("wb_valid", wb_valid, due);
      if (due) begin
        e = exp_q.pop_front();
        eb.rd_addr = (e.bus.rf_wr_en && e.bus.rd != 5'd0) ? e.bus.rd : 5'd0;
        eb.rd      = e.bus.rd_res;
        check_output("wb_bus", wb_bus, e.bus);
        check_output("timeout", timeout, e.to);
        check_output("misalign", misalign, e.mis);
        check_output("bypass", bypass, eb);
        last_wb_res  = wb_bus.rd_res;
        last_wb_rfwe = wb_bus.rf_wr_en;
        last_bypass  = bypass;
        if (timeout)  last_to_cyc  = cyc;
        if (misalign) last_mis_cyc = cyc;
      end else begin
        check_output("timeout_idle", timeout, 1'b0);
        check_output("misalign_idle", misalign, 1'b0);
      end
      in_req  = (cyc >= req_lo) && (cyc <= req_hi);
      in_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check_output("dmem_req", dmem_req, in_req);
      check_output("mem_ready", mem_ready, !in_busy);
      if (in_req) begin
        last_req_we    = dmem_we;
        last_req_addr  = dmem_addr;
        last_req_wdata = dmem_wdata;
        check_output("dmem_addr", dmem_addr, exp_addr);
        check_output("dmem_we", dmem_we, exp_we);
        if (exp_store) check_output("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  // Issue one bundle at a negedge and play the memory side. gd/rd < 0 means "never respond".
  task automatic apply_stimulus(input pipeline_bus_t b, input int gd, input int rd,
                                input logic [31:0] rd_data, output int c);
    exp_t e;
    bit   mis, is_st;
    c     = cyc;
    e.bus = b;
    e.to  = 1'b0;
    e.mis = 1'b0;
    req_lo = 1; req_hi = 0; busy_lo = 1; busy_hi = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = model_misaligned(b.mem_op, b.mem_addr);
`else
    mis = 1'b0;
`endif
    is_st = b.mem_op inside {MEM_SB, MEM_SH, MEM_SW};
    if (b.mem_op == MEM_NOP || mis) begin
      e.cyc = c + 1;
      if (mis) begin
        e.mis = 1'b1;
        e.bus.rf_wr_en = 1'b0;
        e.bus.mem_w_en = 1'b0;
      end
    end else begin
      exp_store = is_st;
      exp_we    = model_we(b.mem_op, b.mem_addr);
      exp_addr  = b.mem_addr & ~32'd3;
      exp_wdata = model_wdata(b.mem_op, b.mem_w_data);
      req_lo  = c + 1;
      busy_lo = c + 1;
      if (gd < 0 || (!is_st && rd < 0)) begin
        e.cyc = c + 1 + MAX_WAIT;
        e.to  = 1'b1;
        e.bus.rf_wr_en = 1'b0;
        busy_hi = c + MAX_WAIT;
        req_hi  = (gd < 0) ? c + MAX_WAIT : c + 1 + gd;
      end else if (is_st) begin
        e.cyc = c + 2 + gd;
        req_hi = c + 1 + gd;
        busy_hi = c + 1 + gd;
      end else begin
        e.cyc = c + 3 + gd + rd;
        req_hi = c + 1 + gd;
        busy_hi = c + 2 + gd + rd;
        e.bus.rd_res = model_load(b.mem_op, b.mem_addr, rd_data);
      end
    end
    exp_q.push_back(e);

    ex_valid = 1'b1;
    ex_bus   = b;
    @(negedge clk);
    ex_valid = 1'b0;
    ex_bus   = rand_bus();
    if (b.mem_op != MEM_NOP && !mis) begin
      if (gd < 0) begin
        repeat (MAX_WAIT) begin
          rvalid = 1'($urandom); rdata = $urandom;
          @(negedge clk);
        end
        rvalid = 1'b0;
      end else begin
        repeat (gd) begin
          rvalid = 1'($urandom); rdata = $urandom;
          @(negedge clk);
        end
        gnt = 1'b1;
        rvalid = 1'($urandom);
        @(negedge clk);
        gnt = 1'b0;
        rvalid = 1'b0;
        if (!is_st) begin
          if (rd < 0) begin
            while (cyc < c + 1 + MAX_WAIT) @(negedge clk);
          end else begin
            repeat (rd) @(negedge clk);
            rvalid = 1'b1;
            rdata  = rd_data;
            @(negedge clk);
            rvalid = 1'b0;
            rdata  = $urandom;
          end
        end
      end
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    check_output("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    pipeline_bus_t b;
    int c, gd, rd;
    ex_valid = 1'b0; ex_bus = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    check_output("rst_wb_valid", wb_valid, 1'b0);
    check_output("rst_wb_bus", wb_bus, '0);
    check_output("rst_req", dmem_req, 1'b0);
    check_output("rst_we", dmem_we, 4'd0);
    check_output("rst_timeout", timeout, 1'b0);
    check_output("rst_misalign", misalign, 1'b0);
    check_output("rst_ready", mem_ready, 1'b1);
    @(negedge clk); @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Case 1: pass-through bundle forwards rd/rd_res
    b = '0; b.mem_op = MEM_NOP; b.rd = 5'd5; b.rf_wr_en = 1'b1; b.rd_res = 32'h1234;
    apply_stimulus(b, 0, 0, 32'd0, c);
    check_output("case1_bypass", last_bypass, {5'd5, 32'h0000_1234});

    // Case 2: byte store at 0x103, grant after 2 cycles
    b = '0; b.mem_op = MEM_SB; b.mem_addr = 32'h103; b.mem_w_data = 32'hAB;
    apply_stimulus(b, 2, 0, 32'd0, c);
    check_output("case2_we", last_req_we, 4'b1000);
    check_output("case2_wdata", last_req_wdata, 32'hABAB_ABAB);
    check_output("case2_addr", last_req_addr, 32'h100);

    // Case 3: signed and unsigned byte load from lane 1
    b = '0; b.mem_op = MEM_LB; b.mem_addr = 32'h101; b.rd = 5'd7; b.rf_wr_en = 1'b1;
    apply_stimulus(b, 1, 1, 32'h0000_8000, c);
    check_output("case3_lb", last_wb_res, 32'hFFFF_FF80);
    b.mem_op = MEM_LBU;
    apply_stimulus(b, 0, 2, 32'h0000_8000, c);
    check_output("case3_lbu", last_wb_res, 32'h0000_0080);

    // Case 4: grant never arrives
    b = '0; b.mem_op = MEM_SW; b.mem_addr = 32'h200; b.rd = 5'd3; b.rf_wr_en = 1'b1;
    apply_stimulus(b, -1, 0, 32'd0, c);
    check_output("case4_latency", last_to_cyc - c, 16);
    check_output("case4_rfwe", last_wb_rfwe, 1'b0);
    check_output("case4_ready", mem_ready, 1'b1);

    // Grant on the last allowed cycle beats the timeout; same for rvalid
    b = '0; b.mem_op = MEM_SH; b.mem_addr = 32'h402; b.mem_w_data = 32'h1357_9BDF;
    apply_stimulus(b, MAX_WAIT - 1, 0, 32'd0, c);
    b = '0; b.mem_op = MEM_LHU; b.mem_addr = 32'h406; b.rd = 5'd9; b.rf_wr_en = 1'b1;
    apply_stimulus(b, 0, MAX_WAIT - 2, 32'hBEEF_1234, c);
    check_output("late_rvalid_res", last_wb_res, 32'h0000_BEEF);

    // Case 5: word load at 0x102
    b = '0; b.mem_op = MEM_LW; b.mem_addr = 32'h102; b.rd = 5'd4; b.rf_wr_en = 1'b1;
    apply_stimulus(b, 0, 0, 32'hCAFE_F00D, c);
`ifdef MEM_MISALIGN_CHECK_EN
    check_output("case5_misalign_cyc", last_mis_cyc - c, 1);
`else
    check_output("case5_addr", last_req_addr, 32'h100);
    check_output("case5_res", last_wb_res, 32'hCAFE_F00D);
`endif

    // Randomized traffic with spurious rvalid while idle
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rvalid = 1'b1; rdata = $urandom;
        @(negedge clk);
        rvalid = 1'b0;
      end
      b  = rand_bus();
      gd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      rd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      apply_stimulus(b, gd, rd, $urandom, c);
    end

    // Case 6: reset mid-access (REQ, then WAIT_R); late responses are ignored
    chk_en = 1'b0;
    @(negedge clk);
    b = '0; b.mem_op = MEM_SW; b.mem_addr = 32'h300;
    ex_valid = 1'b1; ex_bus = b;
    @(negedge clk);
    ex_valid = 1'b0;
    check_output("rst_req_live", dmem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_req_drop", dmem_req, 1'b0);
    check_output("rst_req_ready", mem_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    b.mem_op = MEM_LW; b.rd = 5'd6; b.rf_wr_en = 1'b1;
    ex_valid = 1'b1; ex_bus = b;
    @(negedge clk);
    ex_valid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check_output("rst_waitr_busy", mem_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_waitr_req", dmem_req, 1'b0);
    check_output("rst_waitr_wbv", wb_valid, 1'b0);
    check_output("rst_waitr_ready", mem_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1; gnt = 1'b1; rdata = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rvalid = 1'b0; gnt = 1'b0;
      check_output("post_rst_wbv", wb_valid, 1'b0);
      check_output("post_rst_req", dmem_req, 1'b0);
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
